// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - iterative restoring 32-bit signed/unsigned divider
// One 33-bit trial subtraction per cycle; divide-by-zero and signed overflow resolve at accept.
module seq_divider32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ready,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        qneg_q, rneg_q;
    logic        done_q, dbz_q, ovf_q;
    logic [31:0] quot_q, remd_q;

    logic [32:0] shift_d, trial_d;
    logic [31:0] rem_d, quo_d;
    logic        dvd_neg, dvs_neg, is_zero, is_ovf;
    logic [31:0] dvd_mag, dvs_mag;

    // Shifted partial remainder is kept at 33 bits so a divisor with bit 31 set still divides correctly.
    always_comb begin
        shift_d = {rem_q, quo_q[31]};
        trial_d = shift_d - {1'b0, dvs_q};
        rem_d   = trial_d[32] ? shift_d[31:0] : trial_d[31:0];
        quo_d   = {quo_q[30:0], ~trial_d[32]};
        dvd_neg = op_signed & dividend[31];
        dvs_neg = op_signed & divisor[31];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        is_zero = (divisor == 32'd0);
        is_ovf  = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= 32'd0;
            remd_q  <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_zero) begin
                            quot_q <= 32'hFFFF_FFFF;
                            remd_q <= dividend;
                            dbz_q  <= 1'b1;
                            ovf_q  <= 1'b0;
                            done_q <= 1'b1;
                        end else if (is_ovf) begin
                            quot_q <= 32'h8000_0000;
                            remd_q <= 32'd0;
                            dbz_q  <= 1'b0;
                            ovf_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            rem_q   <= 32'd0;
                            quo_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            rneg_q  <= dvd_neg;
                            qneg_q  <= dvd_neg ^ dvs_neg;
                            cnt_q   <= 6'd0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= qneg_q ? -quo_q : quo_q;
                    remd_q  <= rneg_q ? -rem_q : rem_q;
                    dbz_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/seq_divider32.md
# seq_divider32

Iterative 32-bit integer divider for the NovaEdge32 execute stage, producing quotient and remainder for signed and unsigned division. It sits directly downstream of operand select, beside the 32-bit add/subtract unit. It runs a restoring algorithm: one 33-bit trial subtraction per cycle, 32 iterations. A start/ready/done handshake lets the pipeline stall on it, and divide-by-zero and signed overflow are resolved without iterating.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where ready=1.
- op_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- dividend  input  32  numerator; sampled with start.
- divisor  input  32  denominator; sampled with start.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse: results valid and newly written.
- quotient  output  32  registered quotient; holds until next result write.
- remainder  output  32  registered remainder; holds until next result write.
- div_by_zero  output  1  registered with results; divisor was 0.
- overflow  output  1  registered with results; signed 0x80000000 / 0xFFFFFFFF.

## Operation
- States: IDLE, CALC, FIX.
  - ready=1 only in IDLE.
  - IDLE→CALC on an accepted start (normal case).
  - CALC→FIX after the 32nd iteration.
  - FIX→IDLE always.
- Accept: latch the magnitudes |dividend| and |divisor| (magnitude only when op_signed=1; raw otherwise), the dividend sign, the quotient sign (dividend sign XOR divisor sign), and clear the 6-bit iteration counter.
- Special cases, decided at the accept edge; state stays IDLE and results are written at that same edge:
  - divisor==0, either mode: quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1, overflow=0.
  - op_signed=1, dividend=0x80000000, divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0, overflow=1, div_by_zero=0.
- CALC iteration, per cycle:
  - {rem,quo} shifted left 1; quo LSB takes the next dividend MSB.
  - trial = {1'b0,rem} − {1'b0,divisor_mag}, 33 bits.
  - If trial[32]==0: rem=trial[31:0] and quo LSB=1; else rem is unchanged and quo LSB=0.
- FIX:
  - quotient = quo negated if the quotient sign is set.
  - remainder = rem negated if the dividend sign is set (remainder takes the dividend's sign).
  - Both flags are 0.
  - Unsigned mode performs no negation.
- Flags are rewritten on every result write; they are never sticky.
- start while ready=0 is ignored with no side effects; op_signed, dividend and divisor may change freely while busy.
- A start in the same cycle as done (ready=1) is accepted, so back-to-back operation is supported.

## Timing
- Reset (asynchronous):
  - State=IDLE, ready=1, done=0.
  - quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - Counter and internal registers cleared.
  - Reset mid-CALC aborts the operation; no done pulse follows.
- Normal latency, with start accepted at edge E:
  - Iterations occur at edges E+1..E+32.
  - FIX writes results at edge E+33.
  - done=1 for the cycle after edge E+33.
  - ready=0 for the cycles after edges E..E+32; ready returns to 1 in the same cycle as done.
- Special-case latency: results written at edge E; done=1 for the cycle after E; ready stays 1.
- done is always exactly one cycle wide.
- Outputs change only at result-write edges or on reset.

## Test plan
- Unsigned 100/7, op_signed=0 → done 34 cycles after the start edge; quotient=14, remainder=2, flags 0; ready low for exactly 33 cycles.
- Signed −7/2 (0xFFFFFFF9 / 2) → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1); repeat with 7/−2 → quotient=0xFFFFFFFD, remainder=1.
- Divisor 0 with dividend 5, both modes → done after 1 cycle, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; then 0x80000000 / 0xFFFFFFFF signed → quotient=0x80000000, remainder=0, overflow=1, div_by_zero=0.
- Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0; unsigned 3/0xFFFFFFFF → quotient=0, remainder=3.
- Start 1000/10, pulse start with new operands at cycle 5 (ignored), assert rst at cycle 10 → ready=1, quotient=0, no done pulse; a fresh start 9/3 then gives quotient=3, remainder=0.
- Back-to-back: start held high continuously with a new operand set presented each time ready=1 → consecutive done pulses 34 cycles apart, each with correct results.
